// File: rtl/outport_pkg.sv
// ----------------------------------------------------------------------------
// outport_pkg
//   Constants shared by the output-port block and its sibling GPIO blocks.
//
//   BUS_AW              bus address width in bits
//   OUTPORT_BASE_ADDR   default bus address of an output port
// ----------------------------------------------------------------------------
package outport_pkg;

    localparam int unsigned       BUS_AW            = 32;
    localparam logic [BUS_AW-1:0] OUTPORT_BASE_ADDR = 32'h0100_0000;

endpackage : outport_pkg

// File: rtl/outport_decode.sv
// ----------------------------------------------------------------------------
// outport_decode
//   Exact-match address decoder. The sibling GPIO blocks reuse it.
//   All address bits take part in the compare, so no aliases of ADDR exist.
//
//   Parameters
//     ADDR   address that selects the block
//   Ports
//     addr   in   BUS_AW  bus address
//     hit    out  1       addr equals ADDR
// ----------------------------------------------------------------------------
module outport_decode
    import outport_pkg::*;
#(
    parameter logic [BUS_AW-1:0] ADDR = OUTPORT_BASE_ADDR
) (
    input  logic [BUS_AW-1:0] addr,
    output logic              hit
);

    assign hit = (addr == ADDR);

endmodule : outport_decode

// File: rtl/outport.sv
// ----------------------------------------------------------------------------
// outport
//   Memory-mapped output register. A bus write whose address matches ADDR
//   loads wdata into odata on the next rising clk edge. odata comes straight
//   from a flop, so the pins never see a combinational path from the bus.
//
//   Build option
//     OUTPORT_READBACK_EN  when defined, adds ren / rdata / ready. A read
//                          returns odata zero-extended to the bus width, and
//                          any hit access is acknowledged by a one-cycle
//                          pulse on ready. When undefined, these ports and
//                          their logic are not present.
//
//   Parameters
//     ADDR   bus address of this port (set at every instantiation)
//     WIDTH  width of the output register, 1..32
//   Ports
//     clk     in   1       rising-edge clock
//     resetn  in   1       asynchronous active-low reset
//     addr    in   32      bus address
//     wdata   in   WIDTH   write data
//     wen     in   1       write enable
//     ren     in   1       read enable             (OUTPORT_READBACK_EN)
//     rdata   out  32      readback data           (OUTPORT_READBACK_EN)
//     ready   out  1       access acknowledge      (OUTPORT_READBACK_EN)
//     odata   out  WIDTH   registered port value
// ----------------------------------------------------------------------------
module outport
    import outport_pkg::*;
#(
    parameter logic [BUS_AW-1:0] ADDR  = OUTPORT_BASE_ADDR,
    parameter int                WIDTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [BUS_AW-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              wen,
`ifdef OUTPORT_READBACK_EN
    input  logic              ren,
    output logic [BUS_AW-1:0] rdata,
    output logic              ready,
`endif
    output logic [WIDTH-1:0]  odata
);

    logic hit;

    outport_decode #(
        .ADDR (ADDR)
    ) u_decode (
        .addr (addr),
        .hit  (hit)
    );

    // Output register. Reset is asynchronous, so a write presented while
    // resetn is low is discarded and odata clears without a clock edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            odata <= '0;
        end else if (wen && hit) begin
            odata <= wdata;
        end
    end

`ifdef OUTPORT_READBACK_EN
    // Readback samples the current odata, so a read and a write to the same
    // edge return the value from before the write. ready pulses for every
    // hit access and stays low for other addresses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
            ready <= 1'b0;
        end else begin
            ready <= hit && (wen || ren);
            if (ren && hit) begin
                rdata <= BUS_AW'(odata);
            end
        end
    end
`endif

endmodule : outport

// File: tb/tb_outport.sv
// ----------------------------------------------------------------------------
// tb_outport
//   Directed bench for outport (WIDTH = 8, ADDR = 32'h0100_0000).
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge, or mid-cycle for the asynchronous reset cases.
//   Readback checks are compiled when OUTPORT_READBACK_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_outport;

    localparam logic [31:0] A = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        wen;
    logic [7:0]  odata;
`ifdef OUTPORT_READBACK_EN
    logic        ren;
    logic [31:0] rdata;
    logic        ready;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    outport #(
        .ADDR  (A),
        .WIDTH (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .addr   (addr),
        .wdata  (wdata),
        .wen    (wen),
`ifdef OUTPORT_READBACK_EN
        .ren    (ren),
        .rdata  (rdata),
        .ready  (ready),
`endif
        .odata  (odata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a bus cycle on the falling edge.
    task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic w);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wen   = w;
    endtask

    // Advance to just after the next rising edge.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        addr   = '0;
        wdata  = '0;
        wen    = 1'b0;
`ifdef OUTPORT_READBACK_EN
        ren    = 1'b0;
`endif

        // Reset value, before any clock edge.
        #2;
        check("reset_t0", {24'h0, odata}, 32'h00);
`ifdef OUTPORT_READBACK_EN
        check("reset_t0_rdata", rdata, 32'h0);
        check("reset_t0_ready", {31'h0, ready}, 32'h0);
`endif

        // Release reset without writing: odata stays 0.
        @(negedge clk);
        resetn = 1'b1;
        edge1();
        edge1();
        check("idle_after_reset", {24'h0, odata}, 32'h00);

        // Write presented while reset is held is discarded.
        @(negedge clk);
        resetn = 1'b0;
        addr   = A;
        wdata  = 8'h55;
        wen    = 1'b1;
        edge1();
        check("write_in_reset", {24'h0, odata}, 32'h00);

        // Write pending at release is taken on the first edge.
        @(negedge clk);
        resetn = 1'b1;
        wdata  = 8'h5A;
        edge1();
        check("first_edge_write", {24'h0, odata}, 32'h5A);

        // Hit write 0xAB, then hold with wen=0.
        bus(A, 8'hAB, 1'b1);
        edge1();
        check("hit_write", {24'h0, odata}, 32'hAB);
        bus(A, 8'h33, 1'b0);
        edge1();
        edge1();
        check("hold_wen0", {24'h0, odata}, 32'hAB);

        // Glitch on the bus between edges has no effect.
        @(negedge clk);
        wen   = 1'b1;
        wdata = 8'hFF;
        #2;
        wen   = 1'b0;
        check("glitch_no_edge", {24'h0, odata}, 32'hAB);
        edge1();
        check("glitch_after_edge", {24'h0, odata}, 32'hAB);

        // Miss writes: neighbouring address, zero, and a high-bit alias.
        bus(A + 32'd1, 8'hAC, 1'b1);
        edge1();
        edge1();
        edge1();
        check("miss_addr_plus1", {24'h0, odata}, 32'hAB);
        bus(32'h0, 8'hAC, 1'b1);
        edge1();
        check("miss_addr_zero", {24'h0, odata}, 32'hAB);
        bus(32'h8100_0000, 8'hAC, 1'b1);
        edge1();
        check("miss_addr_msb", {24'h0, odata}, 32'hAB);
        bus(32'h0100_0100, 8'hAC, 1'b1);
        edge1();
        check("miss_addr_mid", {24'h0, odata}, 32'hAB);
        bus(A, 8'h00, 1'b0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_now", {24'h0, odata}, 32'h00);
        #1;
        resetn = 1'b1;
        edge1();
        edge1();
        check("no_recovery", {24'h0, odata}, 32'h00);

        // Back-to-back hit writes.
        bus(A, 8'h11, 1'b1);
        edge1();
        check("b2b_first", {24'h0, odata}, 32'h11);
        @(negedge clk);
        wdata = 8'h22;
        edge1();
        check("b2b_second", {24'h0, odata}, 32'h22);
        bus(A, 8'h00, 1'b0);
        edge1();
        check("b2b_hold", {24'h0, odata}, 32'h22);

`ifdef OUTPORT_READBACK_EN
        // Prepare odata = 0xAB; the write alone is acknowledged.
        bus(A, 8'hAB, 1'b1);
        edge1();
        check("rb_write_ready", {31'h0, ready}, 32'h1);
        bus(A, 8'h00, 1'b0);
        edge1();
        check("rb_idle_ready", {31'h0, ready}, 32'h0);

        // Read hit: one-cycle ready, zero-extended data.
        @(negedge clk);
        ren = 1'b1;
        edge1();
        check("rb_read_ready", {31'h0, ready}, 32'h1);
        check("rb_read_data", rdata, 32'h0000_00AB);
        @(negedge clk);
        ren = 1'b0;
        edge1();
        check("rb_ready_drop", {31'h0, ready}, 32'h0);
        check("rb_data_hold", rdata, 32'h0000_00AB);

        // Read of a foreign address is not acknowledged.
        @(negedge clk);
        addr = 32'h0;
        ren  = 1'b1;
        edge1();
        check("rb_foreign_ready", {31'h0, ready}, 32'h0);
        check("rb_foreign_data", rdata, 32'h0000_00AB);

        // Simultaneous write and read: read returns the pre-write value.
        @(negedge clk);
        addr  = A;
        wdata = 8'hCD;
        wen   = 1'b1;
        ren   = 1'b1;
        edge1();
        check("rb_rw_data", rdata, 32'h0000_00AB);
        check("rb_rw_odata", {24'h0, odata}, 32'hCD);
        check("rb_rw_ready", {31'h0, ready}, 32'h1);
        bus(A, 8'h00, 1'b0);
        ren = 1'b0;

        // Reset clears the readback outputs too.
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("rb_reset_rdata", rdata, 32'h0);
        check("rb_reset_ready", {31'h0, ready}, 32'h0);
        #1;
        resetn = 1'b1;
`endif

        edge1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_outport
